// File: rtl/systolic_result_drain_if.sv
// Stream bundle for systolic_result_drain: per-column C capture inputs and the
// word-serial valid/ready output. slave = drain side, master = producer/sink side.
interface systolic_result_drain_if #(
   parameter int N  = 4,
   parameter int DW = 32
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [N*DW-1:0] c_in;
   logic [N-1:0]    c_valid;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic [CW-1:0]   out_col;
   logic            out_last;

   modport master (
      output c_in, c_valid, out_ready,
      input  out_data, out_valid, out_col, out_last
   );

   modport slave (
      input  c_in, c_valid, out_ready,
      output out_data, out_valid, out_col, out_last
   );
endinterface

// File: rtl/systolic_result_drain.sv
// Bottom-row C collector: skewed column capture -> DEPTH-row FIFO -> word serializer.
// Optional SYS_DRAIN_FTZ_EN flushes exponent-zero float32 words to signed zero at capture.
module systolic_result_drain #(
   parameter int N     = 4,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   systolic_result_drain_if.slave     bus,
   input  logic                       clr_flags_i,
   output logic [$clog2(DEPTH+1)-1:0] rows_pending_o,
   output logic                       ovf_o,
   output logic                       col_err_o
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int RW = $clog2(DEPTH + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [N-1:0][DW-1:0] cap_q, cap_d;
   logic [N-1:0]         mask_q, mask_d;
   logic [N-1:0][DW-1:0] mem_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [RW-1:0]        count_q, count_d;
   logic [N-1:0][DW-1:0] sbuf_q, sbuf_d;
   logic [CW-1:0]        col_q, col_d;
   logic [0:0]           state_q, state_d;
   logic                 ovf_q, ovf_d, col_err_q, col_err_d;
   logic                 commit, fifo_full, fifo_empty, push, pop, last_beat, col_err_set;

   function automatic logic [DW-1:0] ftz(input logic [DW-1:0] w);
`ifdef SYS_DRAIN_FTZ_EN
      if (w[30:23] == 8'd0) return {w[DW-1], {(DW-1){1'b0}}};
      return w;
`else
      return w;
`endif
   endfunction

   // Capture side: a full mask is itself the commit cycle; strobes seen then seed the next row.
   always_comb begin
      commit      = &mask_q;
      fifo_full   = (count_q == RW'(DEPTH));
      fifo_empty  = (count_q == '0);
      push        = commit && !fifo_full;
      cap_d       = cap_q;
      for (int unsigned j = 0; j < N; j++) begin
         if (bus.c_valid[j]) cap_d[j] = ftz(bus.c_in[j*DW +: DW]);
      end
      mask_d      = commit ? bus.c_valid : (mask_q | bus.c_valid);
      col_err_set = !commit && (|(mask_q & bus.c_valid));
      col_err_d   = col_err_set ? 1'b1 : (clr_flags_i ? 1'b0 : col_err_q);
      ovf_d       = (commit && fifo_full) ? 1'b1 : (clr_flags_i ? 1'b0 : ovf_q);
   end

   // Serializer: the final accepted beat reloads straight from the FIFO so rows stream without a bubble.
   always_comb begin
      last_beat = (col_q == CW'(N - 1));
      pop       = 1'b0;
      state_d   = state_q;
      col_d     = col_q;
      sbuf_d    = sbuf_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sbuf_d  = mem_q[rd_ptr_q];
               col_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.out_ready) begin
               if (!last_beat) begin
                  col_d = col_q + CW'(1);
               end else if (!fifo_empty) begin
                  pop    = 1'b1;
                  sbuf_d = mem_q[rd_ptr_q];
                  col_d  = '0;
               end else begin
                  col_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + RW'(push) - RW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q     <= '0;
         mask_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sbuf_q    <= '0;
         col_q     <= '0;
         state_q   <= S_IDLE;
         ovf_q     <= 1'b0;
         col_err_q <= 1'b0;
      end else begin
         cap_q     <= cap_d;
         mask_q    <= mask_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         sbuf_q    <= sbuf_d;
         col_q     <= col_d;
         state_q   <= state_d;
         ovf_q     <= ovf_d;
         col_err_q <= col_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cap_q;
   end

   always_comb begin
      bus.out_valid  = (state_q == S_SEND);
      bus.out_data   = (state_q == S_SEND) ? sbuf_q[col_q] : '0;
      bus.out_col    = (state_q == S_SEND) ? col_q : '0;
      bus.out_last   = (state_q == S_SEND) && last_beat;
      rows_pending_o = count_q;
      ovf_o          = ovf_q;
      col_err_o      = col_err_q;
   end
endmodule
